if_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the MIPS32 pipeline. It owns the PC and drives a wait-state-capable instruction-memory handshake. It obeys the PCWrite/IF_ID_Write stall controls from hazard detection and accepts taken-branch/jump redirects. Its registered output feeds the decode stage.

---
 rtl/mips_pkg.sv | 35 +++
 rtl/if_stage_if.sv | 34 +++
 rtl/if_stage_if_id_reg.sv | 44 ++++
 rtl/if_stage.sv | 149 ++++++++++++++
 tb/tb_if_stage.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared MIPS32 pipeline definitions. Holds datapath width,
//               default reset PC and bubble word, the fetch FSM state
//               encoding, the IF/ID payload type and a saturating increment
//               helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam int XLEN = 32;

  // sll $0,$0,0 - architecturally a no-op, used as the bubble word
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  // Fetch FSM encoding
  localparam logic [0:0] ST_FETCH   = 1'b0;
  localparam logic [0:0] ST_DISCARD = 1'b1;

  // Payload carried by the IF/ID pipeline register
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc4;
    logic            valid;
  } if_id_t;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [XLEN-1:0] sat_inc(input logic [XLEN-1:0] v);
    return (v == {XLEN{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_if
// Description : Instruction-memory request/response handshake.
//               master : fetch stage (drives imem_req / imem_addr)
//               slave  : memory     (drives imem_ready / imem_rdata)
//               A request completes in the cycle imem_req && imem_ready.
// Ports       : none (signal bundle only)
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_if;
  import mips_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/if_stage_if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register. Priority: reset, flush (loads a
//               bubble), write enable (loads d_i), otherwise hold.
// Ports       : clk     - clock
//               reset   - synchronous active-high reset (loads a bubble)
//               flush_i - load a bubble, regardless of we_i
//               we_i    - load d_i
//               d_i     - next IF/ID payload
//               q_o     - registered IF/ID payload
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  wire logic   clk,
  input  wire logic   reset,
  input  wire logic   flush_i,
  input  wire logic   we_i,
  input  wire if_id_t d_i,
  output if_id_t      q_o
);

  localparam if_id_t C_BUBBLE = '{instr: NOP_INSTR, pc4: '0, valid: 1'b0};

  if_id_t r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= C_BUBBLE;
    end else if (flush_i) begin
      r_q <= C_BUBBLE;
    end else if (we_i) begin
      r_q <= d_i;
    end
  end

  assign q_o = r_q;

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : MIPS32 instruction-fetch stage. Owns the PC, drives the
//               instruction-memory handshake, honours PCWrite/IF_ID_Write
//               stalls and branch/jump redirects, and feeds the IF/ID
//               register. A redirect that arrives while a fetch is still
//               outstanding is parked until that fetch completes (DISCARD).
// Ports       : clk, reset            - clock, synchronous active-high reset
//               PCWrite, IF_ID_Write  - hazard-unit stall controls
//               redirect_valid/_pc    - taken branch/jump target
//               imem                  - instruction-memory handshake (master)
//               IF_ID_instr/_pc4/_valid - registered output to decode
//               pc_out                - current PC
//               fetch_stall_cnt       - saturating memory-bubble count
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  wire logic            clk,
  input  wire logic            reset,
  input  wire logic            PCWrite,
  input  wire logic            IF_ID_Write,
  input  wire logic            redirect_valid,
  input  wire logic [XLEN-1:0] redirect_pc,
  imem_if.master               imem,
  output logic [XLEN-1:0]      IF_ID_instr,
  output logic [XLEN-1:0]      IF_ID_pc4,
  output logic                 IF_ID_valid,
  output logic [XLEN-1:0]      pc_out,
  output logic [XLEN-1:0]      fetch_stall_cnt
);

  logic [XLEN-1:0] pc_q,        pc_d;
  logic [XLEN-1:0] redir_buf_q, redir_buf_d;
  logic [0:0]      state_q,     state_d;
  logic [XLEN-1:0] stall_cnt_q;

  logic            w_load;       // capture fetched word into IF/ID
  logic            w_flush;      // write a bubble into IF/ID
  logic            w_cnt_inc;    // this bubble was caused by memory latency
  logic [XLEN-1:0] w_redir_pc;   // word-aligned redirect target
  logic [XLEN-1:0] w_pc4;
  if_id_t          w_if_id_d;
  if_id_t          w_if_id_q;

  assign w_redir_pc = redirect_pc & ~32'h0000_0003;
  assign w_pc4      = pc_q + 32'd4;

  always_comb begin
    pc_d        = pc_q;
    redir_buf_d = redir_buf_q;
    state_d     = state_q;
    w_load      = 1'b0;
    w_flush     = 1'b0;
    w_cnt_inc   = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (redirect_valid && imem.imem_ready) begin
          pc_d    = w_redir_pc;
          w_flush = 1'b1;
        end else if (redirect_valid) begin
          // Current access still in flight: finish it before retargeting
          redir_buf_d = w_redir_pc;
          w_flush     = 1'b1;
          state_d     = ST_DISCARD;
        end else if (imem.imem_ready && PCWrite && IF_ID_Write) begin
          w_load = 1'b1;
          pc_d   = w_pc4;
        end else if (imem.imem_ready) begin
          // Stalled: drop the word, same address is refetched next cycle
        end else if (IF_ID_Write) begin
          w_flush   = 1'b1;
          w_cnt_inc = 1'b1;
        end
      end

      ST_DISCARD: begin
        if (!imem.imem_ready) begin
          if (redirect_valid) begin
            redir_buf_d = w_redir_pc;
          end
          if (IF_ID_Write) begin
            w_flush   = 1'b1;
            w_cnt_inc = 1'b1;
          end
        end else begin
          // Stale word returns here and is thrown away; a redirect arriving
          // in the same cycle is newer than the buffered one
          pc_d      = redirect_valid ? w_redir_pc : redir_buf_q;
          w_flush   = 1'b1;
          w_cnt_inc = 1'b1;
          state_d   = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      redir_buf_q <= '0;
      state_q     <= ST_FETCH;
      stall_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      redir_buf_q <= redir_buf_d;
      state_q     <= state_d;
      if (w_cnt_inc) begin
        stall_cnt_q <= sat_inc(stall_cnt_q);
      end
    end
  end

  assign w_if_id_d = '{instr: imem.imem_rdata, pc4: w_pc4, valid: 1'b1};

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk     (clk),
    .reset   (reset),
    .flush_i (w_flush),
    .we_i    (w_load),
    .d_i     (w_if_id_d),
    .q_o     (w_if_id_q)
  );

  // Request is held high outside reset; the address only moves on a
  // completing cycle, so it is stable across wait states.
  assign imem.imem_req  = ~reset;
  assign imem.imem_addr = pc_q;

  assign IF_ID_instr     = w_if_id_q.instr;
  assign IF_ID_pc4       = w_if_id_q.pc4;
  assign IF_ID_valid     = w_if_id_q.valid;
  assign pc_out          = pc_q;
  assign fetch_stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_stage
// Description : Scoreboard bench for if_stage. Stimulus pushes the expected
//               {instr, pc4} of every fetch that should reach decode; a
//               monitor pops and compares whenever IF/ID is written with a
//               valid instruction. Memory returns addr ^ C_KEY.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;
  import mips_pkg::*;

  localparam logic [31:0] C_KEY = 32'hDEAD_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCWrite;
  logic        IF_ID_Write;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] IF_ID_instr;
  logic [31:0] IF_ID_pc4;
  logic        IF_ID_valid;
  logic [31:0] pc_out;
  logic [31:0] fetch_stall_cnt;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  imem_if imem ();

  assign imem.imem_rdata = imem.imem_addr ^ C_KEY;

  if_stage dut (
    .clk             (clk),
    .reset           (reset),
    .PCWrite         (PCWrite),
    .IF_ID_Write     (IF_ID_Write),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem            (imem.master),
    .IF_ID_instr     (IF_ID_instr),
    .IF_ID_pc4       (IF_ID_pc4),
    .IF_ID_valid     (IF_ID_valid),
    .pc_out          (pc_out),
    .fetch_stall_cnt (fetch_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] addr);
    exp_q.push_back('{instr: addr ^ C_KEY, pc4: addr + 32'd4});
  endtask

  // Apply one cycle of inputs, return at the following negedge
  task automatic drive(input logic rdy, input logic pcw, input logic idw,
                       input logic rv, input logic [31:0] rpc);
    imem.imem_ready = rdy;
    PCWrite         = pcw;
    IF_ID_Write     = idw;
    redirect_valid  = rv;
    redirect_pc     = rpc;
    @(negedge clk);
  endtask

  // Monitor: a valid instruction written into IF/ID must match the oldest
  // outstanding expectation
  initial begin
    logic wr;
    forever begin
      @(posedge clk);
      wr = IF_ID_Write && !reset;
      #1;
      if (wr && IF_ID_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_valid: got pc4 %08h instr %08h expected no valid output",
                   IF_ID_pc4, IF_ID_instr);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (IF_ID_instr !== e.instr) begin
            n_bad++;
            $display("FAIL sb_instr: got %08h expected %08h", IF_ID_instr, e.instr);
          end
          check("sb_pc4", IF_ID_pc4, e.pc4);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset           = 1'b1;
    imem.imem_ready = 1'b1;
    PCWrite         = 1'b1;
    IF_ID_Write     = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    @(negedge clk);

    // Reset state
    check("rst_req",   {31'd0, imem.imem_req}, 32'd0);
    check("rst_pc",    pc_out, 32'd0);
    check("rst_valid", {31'd0, IF_ID_valid}, 32'd0);
    check("rst_instr", IF_ID_instr, 32'd0);
    check("rst_pc4",   IF_ID_pc4, 32'd0);
    check("rst_cnt",   fetch_stall_cnt, 32'd0);

    // Streaming fetch
    reset = 1'b0;
    push_exp(32'h0); drive(1, 1, 1, 0, 0);
    check("req_after_rst", {31'd0, imem.imem_req}, 32'd1);
    check("pc_4", pc_out, 32'h4);
    push_exp(32'h4); drive(1, 1, 1, 0, 0);
    check("pc_8", pc_out, 32'h8);

    // Load-use stall: PC and IF/ID hold, address stable
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 0);
      check("stall_addr",  imem.imem_addr, 32'h8);
      check("stall_pc4",   IF_ID_pc4, 32'h8);
      check("stall_instr", IF_ID_instr, 32'h4 ^ C_KEY);
      check("stall_valid", {31'd0, IF_ID_valid}, 32'd1);
    end
    push_exp(32'h8); drive(1, 1, 1, 0, 0);
    check("pc_c", pc_out, 32'hC);
    push_exp(32'hC); drive(1, 1, 1, 0, 0);
    check("pc_10", pc_out, 32'h10);

    // Memory wait states
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 0, 0);
      check("wait_valid", {31'd0, IF_ID_valid}, 32'd0);
      check("wait_addr",  imem.imem_addr, 32'h10);
    end
    check("wait_cnt", fetch_stall_cnt, 32'd3);
    push_exp(32'h10); drive(1, 1, 1, 0, 0);
    check("wait_pc4", IF_ID_pc4, 32'h14);
    check("pc_14", pc_out, 32'h14);

    // Redirect with request outstanding -> DISCARD
    drive(0, 1, 1, 1, 32'h100);
    check("disc_valid0", {31'd0, IF_ID_valid}, 32'd0);
    check("disc_addr0",  imem.imem_addr, 32'h14);
    check("disc_cnt0",   fetch_stall_cnt, 32'd3);
    drive(0, 1, 1, 0, 0);
    check("disc_addr1",  imem.imem_addr, 32'h14);
    check("disc_cnt1",   fetch_stall_cnt, 32'd4);
    check("disc_valid1", {31'd0, IF_ID_valid}, 32'd0);
    drive(1, 1, 1, 0, 0);
    check("disc_newaddr", imem.imem_addr, 32'h100);
    check("disc_cnt2",    fetch_stall_cnt, 32'd5);
    check("disc_valid2",  {31'd0, IF_ID_valid}, 32'd0);
    push_exp(32'h100); drive(1, 1, 1, 0, 0);
    check("pc_104", pc_out, 32'h104);

    // Redirect overrides IF_ID_Write=0; target is word-aligned
    drive(1, 1, 0, 1, 32'h203);
    check("flush_valid", {31'd0, IF_ID_valid}, 32'd0);
    check("flush_instr", IF_ID_instr, 32'd0);
    check("flush_pc4",   IF_ID_pc4, 32'd0);
    check("flush_pc",    pc_out, 32'h200);

    // PC wrap
    drive(1, 1, 1, 1, 32'hFFFF_FFFC);
    check("pc_top", pc_out, 32'hFFFF_FFFC);
    check("redir_cnt", fetch_stall_cnt, 32'd5);
    push_exp(32'hFFFF_FFFC); drive(1, 1, 1, 0, 0);
    check("wrap_pc",  pc_out, 32'h0);
    check("wrap_pc4", IF_ID_pc4, 32'h0);

    // Counter saturation
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    drive(0, 1, 1, 0, 0);
    check("sat_cnt0", fetch_stall_cnt, 32'hFFFF_FFFF);
    drive(0, 1, 1, 0, 0);
    check("sat_cnt1", fetch_stall_cnt, 32'hFFFF_FFFF);
    push_exp(32'h0); drive(1, 1, 1, 0, 0);
    check("pc_after_sat", pc_out, 32'h4);

    // Reset in the middle of DISCARD
    drive(0, 1, 1, 1, 32'h40);
    reset = 1'b1;
    drive(0, 1, 1, 0, 0);
    check("mid_rst_pc",    pc_out, 32'h0);
    check("mid_rst_req",   {31'd0, imem.imem_req}, 32'd0);
    check("mid_rst_cnt",   fetch_stall_cnt, 32'd0);
    reset = 1'b0;
    push_exp(32'h0); drive(1, 1, 1, 0, 0);
    check("mid_rst_fetch", pc_out, 32'h4);

    drive(0, 1, 0, 0, 0);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
